nmr_compare_voter: RTL and testbench

NMR_COMPARE_VOTER -- requirements
Module: nmr_compare_voter

---
 rtl/nmr_compare_voter.sv | 193 +++++++++++++++++++
 tb/tb_nmr_compare_voter.sv | 354 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nmr_compare_voter.sv
// N-modular-redundancy compare/voter: collects one word per channel,
// optionally injects faults, then compares and majority-votes.
module nmr_compare_voter #(
    parameter int DATA_W   = 32,
    parameter int CHANNELS = 3,
    parameter int TIMEOUT  = 15,
    parameter int CNT_W    = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       clear,
    input  logic [CHANNELS-1:0]        data_set,
    input  logic [CHANNELS*DATA_W-1:0] data,
    input  logic [DATA_W-1:0]          lfsr_mask,
    input  logic                       error_enable,
    input  logic [CHANNELS-1:0]        error_sel,
    input  logic                       cmp_enable,
    output logic [CHANNELS-1:0]        ready,
    output logic                       done,
    output logic                       match,
    output logic [DATA_W-1:0]          voted_data,
    output logic                       vote_valid,
    output logic [CHANNELS-1:0]        fault_chan,
    output logic                       interrupt_mismatch,
    output logic                       interrupt_timeout,
    output logic [CNT_W-1:0]           mismatch_count,
    output logic [11:0]                status_rgb
);

    localparam int TMO_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE,
        COLLECT,
        COMPARE,
        RESULT
    } state_t;

    state_t state, state_n;

    logic [CHANNELS-1:0] set_q;
    logic [CHANNELS-1:0] captured;
    logic [CHANNELS-1:0] cap_mask;
    logic [DATA_W-1:0]   cap_data [CHANNELS];
    logic [TMO_W-1:0]    tmo_cnt;

    logic in_cap;
    logic all_cap;
    logic tmo_hit;
    logic cmp_fire;

    logic                all_eq;
    logic                maj_found;
    logic [DATA_W-1:0]   maj_data;
    logic [CHANNELS-1:0] maj_diff;
    logic [3:0]          vote_cnt;

    // Capture is only open before comparison; clear suppresses it.
    assign in_cap   = (state == IDLE) || (state == COLLECT);
    assign cap_mask = (in_cap && !clear) ?
                      (data_set & ~set_q & ~captured) : '0;
    assign all_cap  = &(captured | cap_mask);
    assign tmo_hit  = (state == COLLECT) && !clear && !all_cap &&
                      (tmo_cnt == TMO_W'(TIMEOUT - 1));
    assign cmp_fire = (state == COMPARE) && !clear;
    assign ready    = in_cap ? ~captured : '0;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    // Next-state logic; clear beats timeout and final capture.
    always_comb begin
        state_n = state;
        unique case (state)
            IDLE: begin
                if (clear)          state_n = IDLE;
                else if (all_cap)   state_n = COMPARE;
                else if (|cap_mask) state_n = COLLECT;
            end
            COLLECT: begin
                if (clear)        state_n = IDLE;
                else if (all_cap) state_n = COMPARE;
                else if (tmo_hit) state_n = RESULT;
            end
            COMPARE: state_n = clear ? IDLE : RESULT;
            RESULT:  state_n = clear ? IDLE : RESULT;
            default: state_n = IDLE;
        endcase
    end

    // Equality check and first-found strict-majority vote.
    always_comb begin
        all_eq    = 1'b1;
        maj_found = 1'b0;
        maj_data  = '0;
        maj_diff  = '0;
        vote_cnt  = '0;
        for (int i = 1; i < CHANNELS; i++) begin
            if (cap_data[i] != cap_data[0]) all_eq = 1'b0;
        end
        for (int i = 0; i < CHANNELS; i++) begin
            vote_cnt = '0;
            for (int j = 0; j < CHANNELS; j++) begin
                if (cap_data[j] == cap_data[i]) vote_cnt = vote_cnt + 4'd1;
            end
            if (!maj_found && (vote_cnt > 4'(CHANNELS / 2))) begin
                maj_found = 1'b1;
                maj_data  = cap_data[i];
            end
        end
        for (int i = 0; i < CHANNELS; i++) begin
            maj_diff[i] = (cap_data[i] != maj_data);
        end
    end

    // Edge detect history and per-channel capture with fault injection.
    always_ff @(posedge clk) begin
        if (rst) begin
            set_q    <= '0;
            captured <= '0;
            for (int i = 0; i < CHANNELS; i++) cap_data[i] <= '0;
        end else begin
            set_q <= data_set;
            for (int i = 0; i < CHANNELS; i++) begin
                if (cap_mask[i]) begin
                    cap_data[i] <= data[i*DATA_W +: DATA_W] ^
                        ((error_enable && error_sel[i]) ? lfsr_mask : '0);
                end
            end
            if (clear || (state_n == IDLE)) captured <= '0;
            else                            captured <= captured | cap_mask;
        end
    end

    // Cycles spent in COLLECT.
    always_ff @(posedge clk) begin
        if (rst)                  tmo_cnt <= '0;
        else if (state == COLLECT) tmo_cnt <= tmo_cnt + 1'b1;
        else                      tmo_cnt <= '0;
    end

    // Result registers: loaded on timeout or COMPARE exit, held until clear.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            done               <= 1'b0;
            match              <= 1'b0;
            voted_data         <= '0;
            vote_valid         <= 1'b0;
            fault_chan         <= '0;
            interrupt_mismatch <= 1'b0;
            interrupt_timeout  <= 1'b0;
            status_rgb         <= 12'h000;
        end else if (tmo_hit) begin
            done              <= 1'b1;
            match             <= 1'b0;
            voted_data        <= '0;
            vote_valid        <= 1'b0;
            fault_chan        <= ~(captured | cap_mask);
            interrupt_timeout <= 1'b1;
            status_rgb        <= 12'h00F;
        end else if (cmp_fire && !cmp_enable) begin
            done       <= 1'b1;
            match      <= 1'b1;
            voted_data <= cap_data[0];
            vote_valid <= 1'b1;
            fault_chan <= '0;
            status_rgb <= 12'h0F0;
        end else if (cmp_fire) begin
            done               <= 1'b1;
            match              <= all_eq;
            voted_data         <= maj_found ? maj_data : '0;
            vote_valid         <= maj_found;
            fault_chan         <= maj_found ? maj_diff : '1;
            interrupt_mismatch <= !all_eq;
            status_rgb         <= all_eq    ? 12'h0F0 :
                                  maj_found ? 12'hFF0 : 12'hF00;
        end
    end

    // Saturating mismatch counter; survives clear, only reset clears it.
    always_ff @(posedge clk) begin
        if (rst) begin
            mismatch_count <= '0;
        end else if (cmp_fire && cmp_enable && !all_eq &&
                     (mismatch_count != '1)) begin
            mismatch_count <= mismatch_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_nmr_compare_voter.sv
// Scoreboard bench for nmr_compare_voter, 3 channels x 32 bits.
module tb_nmr_compare_voter;

    logic        clk;
    logic        rst;
    logic        clear;
    logic [2:0]  data_set;
    logic [95:0] data;
    logic [31:0] lfsr_mask;
    logic        error_enable;
    logic [2:0]  error_sel;
    logic        cmp_enable;
    logic [2:0]  ready;
    logic        done;
    logic        match;
    logic [31:0] voted_data;
    logic        vote_valid;
    logic [2:0]  fault_chan;
    logic        interrupt_mismatch;
    logic        interrupt_timeout;
    logic [15:0] mismatch_count;
    logic [11:0] status_rgb;

    int n_cmp = 0;
    int n_bad = 0;
    logic [15:0] exp_count = '0;

    typedef struct packed {
        logic [31:0] voted;
        logic [18:0] flags;
        logic [15:0] cnt;
    } exp_t;

    exp_t sb[$];
    exp_t e;

    logic [18:0] obs;
    assign obs = {match, vote_valid, fault_chan, interrupt_mismatch,
                  interrupt_timeout, status_rgb};

    nmr_compare_voter dut (
        .clk(clk), .rst(rst), .clear(clear), .data_set(data_set),
        .data(data), .lfsr_mask(lfsr_mask), .error_enable(error_enable),
        .error_sel(error_sel), .cmp_enable(cmp_enable), .ready(ready),
        .done(done), .match(match), .voted_data(voted_data),
        .vote_valid(vote_valid), .fault_chan(fault_chan),
        .interrupt_mismatch(interrupt_mismatch),
        .interrupt_timeout(interrupt_timeout),
        .mismatch_count(mismatch_count), .status_rgb(status_rgb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic exp_t model(input logic [31:0] a, b, c,
                                   input logic cmp, inj,
                                   input logic [2:0] sel,
                                   input logic [31:0] msk,
                                   input logic [15:0] cnt_in);
        exp_t r;
        logic [31:0] x0, x1, x2, vd;
        logic m, v, im;
        logic [2:0] f;
        logic [11:0] st;
        logic [15:0] cn;
        x0 = a ^ ((inj && sel[0]) ? msk : 32'h0);
        x1 = b ^ ((inj && sel[1]) ? msk : 32'h0);
        x2 = c ^ ((inj && sel[2]) ? msk : 32'h0);
        cn = cnt_in;
        im = 1'b0;
        if (!cmp) begin
            m = 1'b1; v = 1'b1; vd = x0; f = 3'b000;
        end else begin
            m = (x0 == x1) && (x1 == x2);
            if (x0 == x1 || x0 == x2) begin v = 1'b1; vd = x0; end
            else if (x1 == x2)        begin v = 1'b1; vd = x1; end
            else                      begin v = 1'b0; vd = 32'h0; end
            f = v ? {x2 != vd, x1 != vd, x0 != vd} : 3'b111;
            if (!m) begin
                im = 1'b1;
                if (cn != 16'hFFFF) cn = cn + 16'd1;
            end
        end
        st = m ? 12'h0F0 : (v ? 12'hFF0 : 12'hF00);
        r.voted = vd;
        r.flags = {m, v, f, im, 1'b0, st};
        r.cnt   = cn;
        return r;
    endfunction

    task automatic strobe(input logic [2:0] m);
        @(negedge clk) data_set = m;
        @(negedge clk) data_set = 3'b000;
    endtask

    task automatic do_clear();
        @(negedge clk) clear = 1'b1;
        @(negedge clk) clear = 1'b0;
    endtask

    task automatic wait_done(input string nm);
        for (int k = 0; k < 40 && !done; k++) @(negedge clk);
        n_cmp++;
        if (!done) begin
            n_bad++;
            $display("FAIL %s_done_wait got done=%b want 1", nm, done);
        end
    endtask

    task automatic setup(input logic [31:0] a, b, c, input logic cmp,
                         input logic inj, input logic [2:0] sel,
                         input logic [31:0] msk);
        data = {c, b, a};
        cmp_enable = cmp;
        error_enable = inj;
        error_sel = sel;
        lfsr_mask = msk;
        sb.push_back(model(a, b, c, cmp, inj, sel, msk, exp_count));
        exp_count = sb[$].cnt;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({ready, done, obs, voted_data, mismatch_count} !==
            {3'b111, 1'b0, 19'h0, 32'h0, 16'h0}) begin
            n_bad++;
            $display("FAIL reset got rdy=%b done=%b fl=%h v=%h c=%0d want 111/0/0/0/0",
                     ready, done, obs, voted_data, mismatch_count);
        end
    endtask

    task automatic test_match();
        setup(32'h55, 32'h55, 32'h55, 1'b1, 1'b0, 3'b000, 32'h0);
        strobe(3'b001);
        strobe(3'b010);
        strobe(3'b100);
        wait_done("match");
        e = sb.pop_front();
        n_cmp++;
        if (obs !== e.flags || voted_data !== e.voted) begin
            n_bad++;
            $display("FAIL match_result got %h/%h want %h/%h",
                     obs, voted_data, e.flags, e.voted);
        end
        n_cmp++;
        if (mismatch_count !== e.cnt) begin
            n_bad++;
            $display("FAIL match_count got %0d want %0d", mismatch_count, e.cnt);
        end
        do_clear();
    endtask

    task automatic test_inject();
        setup(32'h55, 32'h55, 32'h55, 1'b1, 1'b1, 3'b010, 32'hFFFF_FFFF);
        strobe(3'b001);
        strobe(3'b010);
        strobe(3'b100);
        wait_done("inject");
        e = sb.pop_front();
        n_cmp++;
        if (obs !== e.flags || voted_data !== e.voted) begin
            n_bad++;
            $display("FAIL inject_result got %h/%h want %h/%h",
                     obs, voted_data, e.flags, e.voted);
        end
        n_cmp++;
        if (mismatch_count !== e.cnt) begin
            n_bad++;
            $display("FAIL inject_count got %0d want %0d", mismatch_count, e.cnt);
        end
        do_clear();
        error_enable = 1'b0;
    endtask

    task automatic test_no_majority();
        setup(32'h5, 32'h7, 32'h9, 1'b1, 1'b0, 3'b000, 32'h0);
        strobe(3'b111);
        n_cmp++;
        if (done !== 1'b0) begin
            n_bad++;
            $display("FAIL nomaj_early_done got %b want 0", done);
        end
        @(negedge clk);
        n_cmp++;
        if (done !== 1'b1) begin
            n_bad++;
            $display("FAIL nomaj_latency got done=%b want 1", done);
        end
        e = sb.pop_front();
        n_cmp++;
        if (obs !== e.flags || voted_data !== e.voted) begin
            n_bad++;
            $display("FAIL nomaj_result got %h/%h want %h/%h",
                     obs, voted_data, e.flags, e.voted);
        end
        n_cmp++;
        if (mismatch_count !== e.cnt) begin
            n_bad++;
            $display("FAIL nomaj_count got %0d want %0d", mismatch_count, e.cnt);
        end
        do_clear();
    endtask

    task automatic test_cmp_disabled();
        setup(32'h555, 32'h55, 32'h5, 1'b0, 1'b0, 3'b000, 32'h0);
        strobe(3'b001);
        strobe(3'b110);
        wait_done("cmpdis");
        e = sb.pop_front();
        n_cmp++;
        if (obs !== e.flags || voted_data !== e.voted ||
            mismatch_count !== e.cnt) begin
            n_bad++;
            $display("FAIL cmpdis_result got %h/%h/%0d want %h/%h/%0d",
                     obs, voted_data, mismatch_count, e.flags, e.voted, e.cnt);
        end
        do_clear();
        cmp_enable = 1'b1;
    endtask

    task automatic test_timeout();
        data = {32'h0, 32'h55, 32'h55};
        strobe(3'b011);
        repeat (14) @(negedge clk);
        n_cmp++;
        if (done !== 1'b0 || interrupt_timeout !== 1'b0) begin
            n_bad++;
            $display("FAIL timeout_early got done=%b irq=%b want 0/0",
                     done, interrupt_timeout);
        end
        @(negedge clk);
        n_cmp++;
        if ({done, obs, voted_data} !==
            {1'b1, 1'b0, 1'b0, 3'b100, 1'b0, 1'b1, 12'h00F, 32'h0}) begin
            n_bad++;
            $display("FAIL timeout_result got done=%b fl=%h v=%h want 1/%h/0",
                     done, obs, voted_data, 19'h1200F);
        end
        do_clear();
        n_cmp++;
        if ({ready, done, interrupt_timeout, mismatch_count} !==
            {3'b111, 1'b0, 1'b0, exp_count}) begin
            n_bad++;
            $display("FAIL timeout_clear got rdy=%b done=%b irq=%b c=%0d want 111/0/0/%0d",
                     ready, done, interrupt_timeout, mismatch_count, exp_count);
        end
    endtask

    task automatic test_clear_mid();
        data = {32'h1, 32'h2, 32'h3};
        strobe(3'b001);
        n_cmp++;
        if (ready !== 3'b110) begin
            n_bad++;
            $display("FAIL clrmid_ready got %b want 110", ready);
        end
        do_clear();
        n_cmp++;
        if ({ready, done, mismatch_count} !== {3'b111, 1'b0, exp_count}) begin
            n_bad++;
            $display("FAIL clrmid_state got rdy=%b done=%b c=%0d want 111/0/%0d",
                     ready, done, mismatch_count, exp_count);
        end
    endtask

    task automatic test_restrobe();
        setup(32'h55, 32'h55, 32'h55, 1'b1, 1'b0, 3'b000, 32'h0);
        strobe(3'b001);
        data[31:0] = 32'h99;
        strobe(3'b001);
        n_cmp++;
        if (ready !== 3'b110 || done !== 1'b0) begin
            n_bad++;
            $display("FAIL restrobe_ready got %b/%b want 110/0", ready, done);
        end
        strobe(3'b110);
        wait_done("restrobe");
        e = sb.pop_front();
        n_cmp++;
        if (obs !== e.flags || voted_data !== e.voted) begin
            n_bad++;
            $display("FAIL restrobe_result got %h/%h want %h/%h",
                     obs, voted_data, e.flags, e.voted);
        end
        do_clear();
    endtask

    task automatic test_back_to_back();
        logic [31:0] a, b, c;
        for (int t = 0; t < 6; t++) begin
            a = 32'($urandom_range(1, 3));
            b = 32'($urandom_range(1, 3));
            c = 32'($urandom_range(1, 3));
            setup(a, b, c, 1'b1, 1'($urandom_range(0, 1)),
                  3'($urandom_range(0, 7)), 32'h0000_00F0);
            strobe(3'b111);
            wait_done("b2b");
            e = sb.pop_front();
            n_cmp++;
            if (obs !== e.flags || voted_data !== e.voted ||
                mismatch_count !== e.cnt) begin
                n_bad++;
                $display("FAIL b2b_%0d got %h/%h/%0d want %h/%h/%0d", t,
                         obs, voted_data, mismatch_count,
                         e.flags, e.voted, e.cnt);
            end
            do_clear();
        end
        error_enable = 1'b0;
    endtask

    task automatic test_reset_mid();
        data = {32'h4, 32'h4, 32'h4};
        strobe(3'b001);
        @(negedge clk) rst = 1'b1;
        @(negedge clk) rst = 1'b0;
        exp_count = '0;
        n_cmp++;
        if ({ready, done, obs, voted_data, mismatch_count} !==
            {3'b111, 1'b0, 19'h0, 32'h0, exp_count}) begin
            n_bad++;
            $display("FAIL rstmid got rdy=%b done=%b fl=%h v=%h c=%0d want 111/0/0/0/0",
                     ready, done, obs, voted_data, mismatch_count);
        end
    endtask

    initial begin
        rst = 1'b0;
        clear = 1'b0;
        data_set = 3'b000;
        data = '0;
        lfsr_mask = '0;
        error_enable = 1'b0;
        error_sel = 3'b000;
        cmp_enable = 1'b1;
        test_reset();
        test_match();
        test_inject();
        test_no_majority();
        test_cmp_disabled();
        test_timeout();
        test_clear_mid();
        test_restrobe();
        test_back_to_back();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
